// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core's
// load/store path (port 0) and a secondary master (port 1). At most one dmem
// access per cycle, read data is routed back to the issuing port one cycle
// later, and a bounded lock lets one port run atomic read-modify-write
// sequences.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every
// contested idle cycle. The lock timeout still applies, and after a port 0
// timeout port 1 wins exactly one contested cycle. When the macro is not
// defined, contested cycles are arbitrated round-robin.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdt_i,
    input  logic          p0_lock_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdt_o,

    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdt_i,
    input  logic          p1_lock_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdt_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdt_o,
    output logic          mem_wr_o,
    input  logic [DW-1:0] mem_rdt_i,

    output logic          lock_to_o
);

    localparam int          CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW:0] LOCK_LIM = (CW + 1)'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    // Round-robin: the port granted most recently. Fixed priority: stays 1
    // (port 0 favoured) except right after a port 0 timeout, when it is 0
    // until port 1 has won one contested cycle.
    logic          r_last_winner;
    logic          w_last_winner_nxt;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] w_lock_cnt_nxt;
    logic [CW:0]   w_cnt_inc;
    logic          r_lock_to;
    logic          w_lock_to_nxt;

    logic          w_contest;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_rd0;
    logic          w_rd1;

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdt;
    logic          r_rd_pend;
    logic          r_rd_tag;
    logic [DW-1:0] r_p0_rdt;
    logic [DW-1:0] r_p1_rdt;

    assign w_contest = p0_req_i & p1_req_i;

    // Grant decode from the current requests and owner state; forced low
    // while reset is asserted so no access leaks out during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_contest) begin
                    w_gnt0 = r_last_winner;
                    w_gnt1 = ~r_last_winner;
                end else begin
                    w_gnt0 = p0_req_i;
                    w_gnt1 = p1_req_i;
                end
            end
            OWN0:    w_gnt0 = p0_req_i;
            OWN1:    w_gnt1 = p1_req_i;
            default: ;
        endcase
        if (!rst_ni) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign p0_gnt_o = w_gnt0;
    assign p1_gnt_o = w_gnt1;
    assign w_rd0    = w_gnt0 & ~p0_we_i;
    assign w_rd1    = w_gnt1 & ~p1_we_i;

    // Next owner state, lock counter, timeout pulse and arbitration history.
    always_comb begin
        w_state_nxt       = r_state;
        w_lock_cnt_nxt    = r_lock_cnt;
        w_last_winner_nxt = r_last_winner;
        w_lock_to_nxt     = 1'b0;
        w_cnt_inc         = {1'b0, r_lock_cnt} + {{CW{1'b0}}, 1'b1};

`ifdef DMEM_ARB_FIXED_PRIO_EN
        if ((r_state == IDLE) && w_contest) begin
            w_last_winner_nxt = 1'b1;
        end
`else
        if (w_gnt0) begin
            w_last_winner_nxt = 1'b0;
        end else if (w_gnt1) begin
            w_last_winner_nxt = 1'b1;
        end
`endif

        case (r_state)
            IDLE: begin
                if (w_gnt0 && p0_lock_i) begin
                    w_state_nxt    = OWN0;
                    w_lock_cnt_nxt = CW'(1);
                end else if (w_gnt1 && p1_lock_i) begin
                    w_state_nxt    = OWN1;
                    w_lock_cnt_nxt = CW'(1);
                end
            end
            OWN0: begin
                if (w_gnt0 && !p0_lock_i) begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (w_cnt_inc >= LOCK_LIM) begin
                    // Owner held too long: drop it and let port 1 in next.
                    w_state_nxt       = IDLE;
                    w_lock_cnt_nxt    = '0;
                    w_lock_to_nxt     = 1'b1;
                    w_last_winner_nxt = 1'b0;
                end else begin
                    w_lock_cnt_nxt = w_cnt_inc[CW-1:0];
                end
            end
            OWN1: begin
                if (w_gnt1 && !p1_lock_i) begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (w_cnt_inc >= LOCK_LIM) begin
                    w_state_nxt       = IDLE;
                    w_lock_cnt_nxt    = '0;
                    w_lock_to_nxt     = 1'b1;
                    w_last_winner_nxt = 1'b1;
                end else begin
                    w_lock_cnt_nxt = w_cnt_inc[CW-1:0];
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_last_winner <= 1'b1;
            r_lock_cnt    <= '0;
            r_lock_to     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_lock_cnt    <= w_lock_cnt_nxt;
            r_lock_to     <= w_lock_to_nxt;
        end
    end

    assign lock_to_o = r_lock_to;

    // Memory request mux: the granted port drives dmem, otherwise the last
    // granted address/data are held and no write is issued.
    always_comb begin
        mem_addr_o = r_addr;
        mem_wdt_o  = r_wdt;
        if (w_gnt0) begin
            mem_addr_o = p0_addr_i;
            mem_wdt_o  = p0_wdt_i;
        end else if (w_gnt1) begin
            mem_addr_o = p1_addr_i;
            mem_wdt_o  = p1_wdt_i;
        end
        mem_wr_o = (w_gnt0 & p0_we_i) | (w_gnt1 & p1_we_i);
    end

    // Remember the last granted address/data for idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_wdt  <= '0;
        end else if (w_gnt0 || w_gnt1) begin
            r_addr <= mem_addr_o;
            r_wdt  <= mem_wdt_o;
        end
    end

    // Tag each granted read with its port so the returning data is routed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            r_rd_pend <= w_rd0 | w_rd1;
            if (w_rd1) begin
                r_rd_tag <= 1'b1;
            end else if (w_rd0) begin
                r_rd_tag <= 1'b0;
            end
        end
    end

    assign p0_rvalid_o = r_rd_pend & ~r_rd_tag;
    assign p1_rvalid_o = r_rd_pend &  r_rd_tag;
    assign p0_rdt_o    = p0_rvalid_o ? mem_rdt_i : r_p0_rdt;
    assign p1_rdt_o    = p1_rvalid_o ? mem_rdt_i : r_p1_rdt;

    // Per-port read data holding: each port keeps its last returned word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p0_rdt <= '0;
            r_p1_rdt <= '0;
        end else begin
            if (p0_rvalid_o) begin
                r_p0_rdt <= mem_rdt_i;
            end
            if (p1_rvalid_o) begin
                r_p1_rdt <= mem_rdt_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural registered-read
// dmem attached to the memory side.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        p0_req, p0_we, p0_lock;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdt;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdt;

    logic        p1_req, p1_we, p1_lock;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdt;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdt;

    logic [7:0]  mem_addr;
    logic [31:0] mem_wdt;
    logic        mem_wr;
    logic [31:0] mem_rdt;
    logic        lock_to;

    logic [31:0] dmem [0:255];

    int n_chk = 0;
    int n_err = 0;

    dmem_arbiter #(.AW(8), .DW(32), .MAX_LOCK(15)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .p0_req_i    (p0_req),
        .p0_we_i     (p0_we),
        .p0_addr_i   (p0_addr),
        .p0_wdt_i    (p0_wdt),
        .p0_lock_i   (p0_lock),
        .p0_gnt_o    (p0_gnt),
        .p0_rvalid_o (p0_rvalid),
        .p0_rdt_o    (p0_rdt),
        .p1_req_i    (p1_req),
        .p1_we_i     (p1_we),
        .p1_addr_i   (p1_addr),
        .p1_wdt_i    (p1_wdt),
        .p1_lock_i   (p1_lock),
        .p1_gnt_o    (p1_gnt),
        .p1_rvalid_o (p1_rvalid),
        .p1_rdt_o    (p1_rdt),
        .mem_addr_o  (mem_addr),
        .mem_wdt_o   (mem_wdt),
        .mem_wr_o    (mem_wr),
        .mem_rdt_i   (mem_rdt),
        .lock_to_o   (lock_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: registered read (old data on read-then-write), preloaded in reset
    always @(posedge clk) begin
        mem_rdt <= dmem[mem_addr];
        if (!rst_n) begin
            dmem[8'h02] <= 32'h2222_2222;
            dmem[8'h10] <= 32'hDEAD_BEEF;
            dmem[8'h20] <= 32'h0000_0005;
            dmem[8'h30] <= 32'h0000_0033;
        end else if (mem_wr) begin
            dmem[mem_addr] <= mem_wdt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic lk);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdt = d; p0_lock = lk;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic lk);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdt = d; p1_lock = lk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

        // reset values
        #2;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_lock_to", lock_to, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdt", mem_wdt, 0);
        chk("rst_p0_rdt", p0_rdt, 0);
        chk("rst_p1_rdt", p1_rdt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single p0 read of 0x10
        @(negedge clk);
        set_p0(1'b1, 1'b0, 8'h10, 32'h0, 1'b0);
        #1;
        chk("t1_p0_gnt", p0_gnt, 1);
        chk("t1_p1_gnt", p1_gnt, 0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_wr", mem_wr, 0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("t1_p0_rvalid", p0_rvalid, 1);
        chk("t1_p0_rdt", p0_rdt, 32'hDEAD_BEEF);
        chk("t1_p1_rvalid", p1_rvalid, 0);
        chk("t1_addr_hold", mem_addr, 32'h10);
        @(negedge clk);
        #1;
        chk("t1_p0_rvalid_off", p0_rvalid, 0);
        chk("t1_p0_rdt_hold", p0_rdt, 32'hDEAD_BEEF);

        // single p1 read of 0x02, then both ports contend every cycle
        @(negedge clk);
        set_p1(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
        #1;
        chk("t2_p1_solo_gnt", p1_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_p0(1'b1, 1'b1, 8'h01, 32'h11, 1'b0);
            set_p1(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
            #1;
            chk("t2_p0_gnt", p0_gnt, (i % 2 == 0));
            chk("t2_p1_gnt", p1_gnt, (i % 2 == 1));
            chk("t2_mem_wr", mem_wr, (i % 2 == 0));
            chk("t2_mem_addr", mem_addr, (i % 2 == 0) ? 32'h01 : 32'h02);
            chk("t2_p1_rvalid", p1_rvalid, (i % 2 == 0));
            if (i % 2 == 0) chk("t2_p1_rdt", p1_rdt, 32'h2222_2222);
        end

        // p1 locked read-modify-write on 0x20 while p0 keeps requesting 0x30
        @(negedge clk);
        set_p0(1'b1, 1'b0, 8'h30, 32'h0, 1'b0);
        set_p1(1'b1, 1'b0, 8'h20, 32'h0, 1'b1);
        #1;
        chk("t3_p1_lock_gnt", p1_gnt, 1);
        chk("t3_p0_gnt_a", p0_gnt, 0);
        @(negedge clk);
        set_p1(1'b0, 1'b0, 8'h20, 32'h0, 1'b0);
        #1;
        chk("t3_p0_gnt_b", p0_gnt, 0);
        chk("t3_p1_rvalid", p1_rvalid, 1);
        chk("t3_p1_rdt", p1_rdt, 32'h5);
        @(negedge clk);
        set_p1(1'b1, 1'b1, 8'h20, 32'h6, 1'b0);
        #1;
        chk("t3_p1_unlock_gnt", p1_gnt, 1);
        chk("t3_p0_gnt_c", p0_gnt, 0);
        chk("t3_mem_wr", mem_wr, 1);
        @(negedge clk);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("t3_p0_gnt_d", p0_gnt, 1);
        chk("t3_mem_addr_d", mem_addr, 32'h30);
        // read of 0x30 then write to 0x30 back-to-back returns old data
        @(negedge clk);
        set_p0(1'b1, 1'b1, 8'h30, 32'h44, 1'b0);
        #1;
        chk("t3_p0_gnt_e", p0_gnt, 1);
        chk("t3_p0_rvalid_e", p0_rvalid, 1);
        chk("t3_war_old_data", p0_rdt, 32'h33);
        chk("t3_mem_wr_e", mem_wr, 1);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("t3_p0_rvalid_f", p0_rvalid, 0);
        chk("t3_mem20", dmem[8'h20], 32'h6);
        chk("t3_mem30", dmem[8'h30], 32'h44);
        chk("t3_p0_rdt_hold", p0_rdt, 32'h33);

        // p0 takes a lock and goes idle until the timeout frees it
        @(negedge clk);
        set_p0(1'b1, 1'b0, 8'h10, 32'h0, 1'b1);
        #1;
        chk("t4_p0_lock_gnt", p0_gnt, 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
            set_p1(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
            #1;
            chk("t4_lock_to", lock_to, (k == 15));
            chk("t4_p1_gnt", p1_gnt, (k >= 15));
            chk("t4_p0_gnt", p0_gnt, 0);
            if (k == 1) begin
                chk("t4_p0_rvalid", p0_rvalid, 1);
                chk("t4_p0_rdt", p0_rdt, 32'hDEAD_BEEF);
            end
        end

        // reset asserted mid-lock with a read pending
        @(negedge clk);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_p0(1'b1, 1'b0, 8'h10, 32'h0, 1'b1);
        #1;
        chk("t5_p0_lock_gnt", p0_gnt, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_p0_gnt", p0_gnt, 0);
        chk("t5_rst_p0_rvalid", p0_rvalid, 0);
        chk("t5_rst_p0_rdt", p0_rdt, 0);
        chk("t5_rst_mem_wr", mem_wr, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        chk("t5_rst_lock_to", lock_to, 0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_no_stale_rvalid", p0_rvalid, 0);
        @(negedge clk);
        set_p1(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
        #1;
        chk("t5_idle_p1_gnt", p1_gnt, 1);

        // both ports contend for four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_p0(1'b1, 1'b0, 8'h01, 32'h0, 1'b0);
            set_p1(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
            #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            chk("t6_p0_gnt", p0_gnt, 1);
            chk("t6_p1_gnt", p1_gnt, 0);
`else
            chk("t6_p0_gnt", p0_gnt, (i % 2 == 0));
            chk("t6_p1_gnt", p1_gnt, (i % 2 == 1));
`endif
        end
        @(negedge clk);
        set_p0(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_p1(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem) between two requesters.
  - Port 0: the core's load/store path.
  - Port 1: a secondary master, e.g. a debug/DMA loader.
- Sits between the requesters and dmem.
- Issues at most one dmem access per cycle and routes read data back to the port that issued the read.
- Supports a bounded lock so one requester can do atomic read-modify-write sequences.

Parameters:
- AW, 8, address width (dmem is 256 words).
- DW, 32, data width.
- MAX_LOCK, 15, maximum consecutive cycles a locked owner may keep the grant before it is forcibly released.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- p0_req_i  in  1  port 0 access request
- p0_we_i  in  1  port 0 write enable (1 = write, 0 = read)
- p0_addr_i  in  AW  port 0 address
- p0_wdt_i  in  DW  port 0 write data
- p0_lock_i  in  1  port 0 requests to keep ownership after this access
- p0_gnt_o  out  1  port 0 access accepted this cycle
- p0_rvalid_o  out  1  port 0 read data valid
- p0_rdt_o  out  DW  port 0 read data
- p1_*  same set as p0_*, for port 1
- mem_addr_o  out  AW  to dmem addr_i
- mem_wdt_o  out  DW  to dmem wr_dt_i
- mem_wr_o  out  1  to dmem wr_en_i
- mem_rdt_i  in  DW  from dmem rd_dt_o (registered read, 1-cycle latency)
- lock_to_o  out  1  single-cycle pulse when a lock is forcibly released

Behaviour:
- Clocking and reset:
  - Single clock, clk_i.
  - rst_ni is asynchronous and active-low.
  - All state registers clear immediately on reset assertion.
- Reset values:
  - gnt, rvalid, mem_wr_o and lock_to_o are 0.
  - rdt and mem_addr_o/mem_wdt_o are 0.
  - Arbiter state is IDLE.
  - last_winner = 1, so port 0 wins the first contested cycle.
  - lock_cnt = 0.
- Grant is combinational from the current request and registered state. A handshake completes in the cycle where req and gnt are both 1.
- Requesters hold req/we/addr/wdt/lock stable until granted.
- State machine states:
  - IDLE: no owner.
  - OWN0: port 0 holds a lock.
  - OWN1: port 1 holds a lock.
- IDLE behaviour:
  - Only one req: grant that port.
  - Both req: grant the port that is not last_winner. last_winner updates on every grant.
  - Granted with lock_i=1: go to OWNx, lock_cnt = 1.
- OWNx behaviour:
  - Only port x may be granted; the other port's gnt is 0 even if it requests.
  - Port x granted with lock_i=0: return to IDLE, lock_cnt = 0.
  - Port x idle (req=0): state is held and lock_cnt still increments.
  - lock_cnt reaches MAX_LOCK: forced to IDLE, lock_to_o pulses for 1 cycle, last_winner = x, so the other port wins the next contested cycle. Any access granted in that same cycle still completes.
- Memory drive:
  - mem_addr_o and mem_wdt_o are the granted port's fields (combinational mux).
  - mem_wr_o = gnt & we.
  - No grant: mem_wr_o = 0 and address holds the last granted value.
- Read return:
  - A granted read sets a 1-bit tag register (owner) and rd_pend.
  - Next cycle: px_rvalid_o = 1 for the tagged port only, and px_rdt_o = mem_rdt_i.
  - The non-tagged port's rdt holds its previous value.
- Back-to-back accesses: a read granted in cycle N and any access granted in N+1 are both legal; rvalid for N appears in N+1. No bubbles.
- Write-after-read to the same address in consecutive cycles returns the old data, as dmem does.
- Reset mid-lock: state returns to IDLE; any pending rvalid is discarded.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined:
  - Port 0 always wins contested IDLE cycles; last_winner is ignored.
  - MAX_LOCK timeout still applies, but after a timeout of port 0, port 1 wins exactly one contested cycle.
- Not defined: round-robin as described in Behaviour.

Test Plan:
- Reset, then p0 read addr 0x10 with dmem[0x10]=0xDEADBEEF → p0_gnt same cycle; p0_rvalid=1 and p0_rdt=0xDEADBEEF next cycle; p1_rvalid stays 0.
- Both ports request every cycle (p0 writes 0x11 to addr 0x01, p1 reads addr 0x02) → grants alternate p0,p1,p0,p1; mem_wr_o=1 only on p0 cycles.
- p1 locks: reads 0x20, lock=1, then writes 0x20 with lock=0; p0 requesting throughout → p0_gnt=0 until p1's unlocking write is granted, then p0 is granted next cycle.
- p0 locks and goes idle with MAX_LOCK=15 → lock_to_o pulses exactly 15 cycles after the lock grant; p1, requesting throughout, is granted that cycle or the next.
- Assert rst_ni low mid-lock with a read pending → all outputs 0 asynchronously; after release, state is IDLE and no stale rvalid appears.
- With DMEM_ARB_FIXED_PRIO_EN defined, both ports requesting continuously for 4 cycles → p0 granted all 4 cycles.
